// File: rtl/nn_alu_pkg.sv
// Shared definitions for the two-stage neuron ALU and its issuing sequencer:
// opcode constants, sequencer state encoding and the default datapath width.
package nn_alu_pkg;

  localparam int NBITS_DEFAULT = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_MUL  = 3'b001;
  localparam logic [2:0] ALU_SGE  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/neuron_mac_sequencer.sv
// Streams (input, weight) pairs through the external ALU as acc + x*w,
// then presents the final sum with a step activation on a valid/ready port.
module neuron_mac_sequencer
  import nn_alu_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [NBITS-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  output logic [NBITS-1:0] alu_src_a,
  output logic [NBITS-1:0] alu_src_b,
  output logic [NBITS-1:0] alu_src_c,
  output logic [2:0]       alu1_ctrl,
  output logic [2:0]       alu2_ctrl,
  input  logic [NBITS-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_sum,
  output logic             out_act,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; the sender holds data stable while valid is high and ready low.

  seq_state_t       state_q, state_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NBITS-1:0] sum_d;
  logic             act_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      out_sum   <= '0;
      out_act   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      out_sum   <= sum_d;
      out_act   <= act_d;
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sum_d     = out_sum;
    act_d     = out_act;
    in_ready  = 1'b0;
    alu_src_a = '0;
    alu_src_b = '0;
    alu_src_c = '0;
    alu1_ctrl = ALU_PASS;
    alu2_ctrl = ALU_PASS;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = bias;
          count_d = num_terms;
          if (num_terms == '0) begin
            state_d = ST_DONE;
            sum_d   = bias;
            act_d   = ~bias[NBITS-1];
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        // The ALU is only driven with real operands on a handshake cycle.
        if (in_valid) begin
          alu_src_a = in_a;
          alu_src_b = in_b;
          alu_src_c = acc_q;
          alu1_ctrl = ALU_MUL;
          alu2_ctrl = ALU_ADD;
          acc_d     = alu_result;
          count_d   = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            sum_d   = alu_result;
            act_d   = ~alu_result[NBITS-1];
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
